// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 definitions (RAM geometry defaults and loader FSM encoding).
package sap1_pkg;
    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} loader_state_t;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into the SAP-1 RAM one word at a time, then verifies a trailing
// modulo-2^DATA_W checksum byte and releases the CPU only on a match.
module ram_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_W = SAP1_ADDR_W,
    parameter int DATA_W = SAP1_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run
);
    loader_state_t state, next;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] sum;
    logic last;

    assign last = count == {ADDR_W{1'b1}};
    assign byte_ready = state == LOAD || state == CHECK;
    assign ram_address = (state == IDLE || state == DONE) ? cpu_address : count;

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? LOAD : state;
            LOAD:       next = byte_valid ? WRITE : LOAD;
            WRITE:      next = last ? CHECK : LOAD;
            CHECK:      next = byte_valid ? DONE : CHECK;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= IDLE;
        else
            state <= next;
    end

    // Strobes are registered from the next state so they line up exactly with the state they flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count            <= '0;
            sum              <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            cpu_run          <= 1'b0;
        end else begin
            ram_write_enable <= next == WRITE;
            busy             <= next == LOAD || next == WRITE || next == CHECK;
            case (state)
                IDLE, DONE: if (start) begin
                    count   <= '0;
                    sum     <= '0;
                    done    <= 1'b0;
                    error   <= 1'b0;
                    cpu_run <= 1'b0;
                end
                LOAD: if (byte_valid) ram_data_in <= byte_data;
                WRITE: begin
                    sum <= sum + ram_data_in;
                    if (!last) count <= count + 1'b1;
                end
                CHECK: if (byte_valid) begin
                    done    <= 1'b1;
                    error   <= byte_data != sum;
                    cpu_run <= byte_data == sum;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed and randomized load sessions checked against a plain byte-list and
// running-sum model of the loader, with a RAM image rebuilt from observed write strobes.
module tb_ram_loader;
    logic       clk = 0;
    logic       clr_n = 0;
    logic       start = 0;
    logic       byte_valid = 0;
    logic [7:0] byte_data = 0;
    logic       byte_ready;
    logic [3:0] cpu_address = 0;
    logic       ram_write_enable;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic       busy, done, error, cpu_run;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] mem[16];
    logic [7:0] exp_mem[16];
    logic       we_prev = 0;
    int         dbl = 0;

    ram_loader dut (
        .clk(clk), .clr_n(clr_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .cpu_address(cpu_address), .ram_write_enable(ram_write_enable),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .busy(busy), .done(done),
        .error(error), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: whatever the loader strobes in is what the RAM holds.
    always @(negedge clk) begin
        if (ram_write_enable) begin
            wa.push_back(ram_address);
            wd.push_back(ram_data_in);
            mem[ram_address] = ram_data_in;
            if (we_prev) dbl++;
        end
        we_prev = ram_write_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_we"}, ram_write_enable, 0);
        check({tag, "_ready"}, byte_ready, 0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        int n;
        byte_valid = 0;
        repeat (gap) @(posedge clk);
        #1;
        byte_data = b;
        byte_valid = 1;
        acc = 0;
        n = 0;
        do begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 20);
        byte_valid = 0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic begin_session();
        @(posedge clk);
        #1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", error, 0);
    endtask

    task automatic run_session(input logic [7:0] d[16], input logic [7:0] cks, input int gap,
                               input int glitch);
        int sum = 0;
        logic [7:0] s8;
        wa.delete();
        wd.delete();
        dbl = 0;
        begin_session();
        for (int i = 0; i < 16; i++) begin
            if (i == glitch) begin
                @(posedge clk);
                #1;
                start = 1;
                check("glitch_in_load", byte_ready, 1);
                @(posedge clk);
                #1;
                start = 0;
                check("glitch_busy", busy, 1);
            end
            send(d[i], gap);
            exp_mem[i] = d[i];
            sum += d[i];
        end
        s8 = 8'(sum % 256);
        send(cks, gap);
        @(negedge clk);
        check("done", done, 1);
        check("error", error, cks != s8);
        check("cpu_run", cpu_run, cks == s8);
        check("busy_end", busy, 0);
        check("write_count", wa.size(), 16);
        check("single_cycle", dbl, 0);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            check($sformatf("waddr%0d", i), wa[i], i);
            check($sformatf("wdata%0d", i), wd[i], d[i]);
        end
        for (int i = 0; i < 16; i++) check($sformatf("mem%0d", i), mem[i], exp_mem[i]);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done, 1);
        check("error_hold", error, cks != s8);
    endtask

    initial begin
        logic [7:0] d[16];
        int sum;
        int nw;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'hxx;
            exp_mem[i] = 8'hxx;
        end
        #3;
        check_reset_outputs("reset");
        #20;
        clr_n = 1;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

        for (int a = 0; a < 16; a++) begin
            cpu_address = 4'(a);
            #1;
            check($sformatf("pass_addr%0d", a), ram_address, a);
            check("pass_we", ram_write_enable, 0);
        end

        for (int i = 0; i < 16; i++) d[i] = 8'(i);
        run_session(d, 8'h78, 0, -1);
        run_session(d, 8'h00, 0, -1);
        run_session(d, 8'h78, 3, -1);
        run_session(d, 8'h78, 0, 3);

        for (int r = 0; r < 3; r++) begin
            sum = 0;
            for (int i = 0; i < 16; i++) begin
                d[i] = 8'($urandom);
                sum += d[i];
            end
            run_session(d, (r == 1) ? 8'(sum % 256) ^ 8'($urandom_range(1, 255)) : 8'(sum % 256),
                        $urandom_range(0, 2), -1);
        end

        wa.delete();
        begin_session();
        for (int i = 0; i < 5; i++) begin
            d[i] = 8'($urandom);
            send(d[i], 0);
            if (i < 4) exp_mem[i] = d[i];
        end
        check("mid_write_we", ram_write_enable, 1);
        #2;
        clr_n = 0;
        #1;
        check_reset_outputs("async_reset");
        nw = wa.size();
        check("writes_before_reset", nw, 4);
        #10;
        clr_n = 1;
        byte_valid = 1;
        byte_data = 8'hA5;
        repeat (6) @(posedge clk);
        #1;
        byte_valid = 0;
        check("no_write_after_reset", wa.size(), nw);
        check("still_idle", busy, 0);
        for (int i = 0; i < 16; i++) check($sformatf("post_reset_mem%0d", i), mem[i], exp_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
